// File: rtl/ascon_pkg.sv
// Shared Ascon types, round-count limits and the constant/substitution/diffusion layers.
package ascon_pkg;

  localparam int unsigned ASCON_WORD_W     = 64;
  localparam int unsigned ASCON_WORDS      = 5;
  localparam int unsigned ASCON_MAX_ROUNDS = 12;

  typedef logic [ASCON_WORD_W-1:0]        ascon_word_t;
  typedef ascon_word_t [ASCON_WORDS-1:0]  ascon_state_t;
  typedef logic [3:0]                     ascon_rnd_t;

  // Constant index i yields {0xF-i, i}, e.g. 0xF0 for i=0 and 0x4B for i=11.
  function automatic logic [7:0] ascon_rc(input ascon_rnd_t idx);
    return {4'hf - idx, idx};
  endfunction

  function automatic ascon_word_t ascon_ror(input ascon_word_t x, input int unsigned n);
    return (x >> n) | (x << (ASCON_WORD_W - n));
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  function automatic ascon_state_t ascon_sbox(input ascon_state_t s);
    ascon_state_t x;
    ascon_state_t t;
    x = s;
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    return x;
  endfunction

  function automatic ascon_state_t ascon_linear(input ascon_state_t s);
    ascon_state_t x;
    x[0] = s[0] ^ ascon_ror(s[0], 19) ^ ascon_ror(s[0], 28);
    x[1] = s[1] ^ ascon_ror(s[1], 61) ^ ascon_ror(s[1], 39);
    x[2] = s[2] ^ ascon_ror(s[2], 1)  ^ ascon_ror(s[2], 6);
    x[3] = s[3] ^ ascon_ror(s[3], 10) ^ ascon_ror(s[3], 17);
    x[4] = s[4] ^ ascon_ror(s[4], 7)  ^ ascon_ror(s[4], 41);
    return x;
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Control/data bus between a mode controller and the permutation engine.
interface ascon_perm_engine_if;
  import ascon_pkg::*;

  logic        start_i;
  ascon_rnd_t  nr_i;
  logic [2:0]  word_sel_i;
  ascon_word_t data_i;
  logic        write_en_i;
  logic        xor_en_i;
  ascon_word_t data_o;
  logic        ready_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output start_i, nr_i, word_sel_i, data_i, write_en_i, xor_en_i,
    input  data_o, ready_o, done_o, err_o
  );

  modport slave (
    input  start_i, nr_i, word_sel_i, data_i, write_en_i, xor_en_i,
    output data_o, ready_o, done_o, err_o
  );
endinterface

// File: rtl/ascon_round.sv
// One full Ascon round: constant addition, substitution, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_rnd_t   rnd_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  ascon_state_t added;

  always_comb begin
    added          = state_i;
    added[2][7:0]  = state_i[2][7:0] ^ ascon_rc(rnd_i);
  end

  assign state_o = ascon_linear(ascon_sbox(added));

endmodule

// File: rtl/ascon_perm_engine.sv
// Ascon-p[nr] engine: 320-bit state, UNROLL rounds per clock, word access while idle.
module ascon_perm_engine
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ascon_perm_engine_if.slave bus
);

  localparam ascon_rnd_t UNR  = ascon_rnd_t'(UNROLL);
  localparam ascon_rnd_t MAXR = ascon_rnd_t'(ASCON_MAX_ROUNDS);

  typedef enum logic {IDLE, PERM} state_e;

  state_e       state_q, state_d;
  ascon_state_t st_q, st_d;
  ascon_rnd_t   rem_q, rem_d;
  ascon_rnd_t   rc_q, rc_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  ascon_rnd_t   n_c;
  ascon_rnd_t   nr_eff;
  ascon_state_t chain [UNROLL+1];

  // Rounds applied this edge; the last cycle may carry fewer than UNROLL.
  assign n_c    = (rem_q < UNR) ? rem_q : UNR;
  assign nr_eff = (bus.nr_i > MAXR) ? MAXR : bus.nr_i;

  assign chain[0] = st_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    ascon_state_t rnd_out;

    ascon_round u_round (
      .rnd_i   (rc_q + ascon_rnd_t'(j)),
      .state_i (chain[j]),
      .state_o (rnd_out)
    );

    assign chain[j+1] = (ascon_rnd_t'(j) < n_c) ? rnd_out : chain[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rem_q   <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rem_q   <= rem_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rem_d   = rem_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write lands on the start edge so the rounds see the written word.
        for (int w = 0; w < 5; w++) begin
          if (bus.write_en_i && (3'(w) == bus.word_sel_i)) begin
            st_d[w] = bus.xor_en_i ? (st_q[w] ^ bus.data_i) : bus.data_i;
          end
        end
        if (bus.start_i) begin
          if (nr_eff == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = nr_eff;
            rc_d    = MAXR - nr_eff;
            state_d = PERM;
          end
        end
      end
      PERM: begin
        st_d  = chain[UNROLL];
        rem_d = rem_q - n_c;
        rc_d  = rc_q + n_c;
        if (rem_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        err_d = bus.write_en_i | bus.start_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.data_o = '0;
    for (int w = 0; w < 5; w++) begin
      if (3'(w) == bus.word_sel_i) bus.data_o = st_q[w];
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;

endmodule
